// File: rtl/ps2_key_event_ctrl_if.sv
// Key-event handshake bundle between the PS/2 controller (master) and its consumer (slave).
interface ps2_key_event_ctrl_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_release;

  modport master (output evt_valid, evt_code, evt_ext, evt_release, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_ext, evt_release, output evt_ready);
endinterface

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 keyboard front end: pin sync, frame capture, E0/F0 prefix decode, event FIFO.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking of each frame.
module ps2_key_event_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kclk,
  input  logic                  kdata,
  ps2_key_event_ctrl_if.master  evt,
  output logic                  frame_err,
  output logic                  overflow
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} fstate_t;
  typedef enum logic [1:0] {D_BASE, D_EXT, D_BRK, D_EXT_BRK} dstate_t;

  logic [SYNC_STAGES-1:0] kclk_sync, kdata_sync;
  logic                   kclk_prev, kclk_s, kdata_s, fall;

  fstate_t    fstate, fstate_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n;
  logic [TW-1:0] cnt, cnt_n;
  logic       byte_done, byte_done_n, ferr_n, par_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic       par, par_n;
`endif

  dstate_t    dstate, dstate_n;
  logic       push;
  logic [9:0] push_data;

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic        full, pop, wr;
  logic [9:0]  head;

  assign kclk_s  = kclk_sync[SYNC_STAGES-1];
  assign kdata_s = kdata_sync[SYNC_STAGES-1];
  assign fall    = kclk_prev & ~kclk_s;

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shreg, par};
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    fstate_n    = fstate;
    idx_n       = idx;
    shreg_n     = shreg;
    byte_done_n = 1'b0;
    ferr_n      = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_n       = par;
`endif
    cnt_n = (fstate == F_IDLE || fall) ? '0 : cnt + 1'b1;
    if (fall) begin
      case (fstate)
        F_IDLE: begin
          if (!kdata_s) begin
            fstate_n = F_DATA;
            idx_n    = '0;
          end else begin
            ferr_n = 1'b1;
          end
        end
        F_DATA: begin
          shreg_n[idx] = kdata_s;
          if (idx == 3'd7) fstate_n = F_PARITY;
          else             idx_n    = idx + 1'b1;
        end
        F_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_n = kdata_s;
`endif
          fstate_n = F_STOP;
        end
        default: begin
          if (kdata_s && par_ok) byte_done_n = 1'b1;
          else                   ferr_n      = 1'b1;
          fstate_n = F_IDLE;
        end
      endcase
    end else if (fstate != F_IDLE && cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      fstate_n = F_IDLE;
      ferr_n   = 1'b1;
      cnt_n    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kclk_sync  <= '1;
      kdata_sync <= '1;
      kclk_prev  <= 1'b1;
      fstate     <= F_IDLE;
      idx        <= '0;
      shreg      <= '0;
      cnt        <= '0;
      byte_done  <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par        <= 1'b0;
`endif
    end else begin
      kclk_sync  <= {kclk_sync[SYNC_STAGES-2:0], kclk};
      kdata_sync <= {kdata_sync[SYNC_STAGES-2:0], kdata};
      kclk_prev  <= kclk_s;
      fstate     <= fstate_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      byte_done  <= byte_done_n;
      frame_err  <= ferr_n;
`ifdef PS2_PARITY_CHECK_EN
      par        <= par_n;
`endif
    end
  end

  // shreg is untouched in STOP, so it still holds the byte while byte_done is high
  always_comb begin
    dstate_n  = dstate;
    push      = 1'b0;
    push_data = '0;
    if (frame_err) begin
      dstate_n = D_BASE;
    end else if (byte_done) begin
      case (dstate)
        D_BASE: begin
          if (shreg == 8'hE0)      dstate_n = D_EXT;
          else if (shreg == 8'hF0) dstate_n = D_BRK;
          else if (shreg != 8'hAA && shreg != 8'hFA) begin
            push      = 1'b1;
            push_data = {2'b00, shreg};
          end
        end
        D_EXT: begin
          if (shreg == 8'hF0) dstate_n = D_EXT_BRK;
          else if (shreg != 8'hE0) begin
            push      = 1'b1;
            push_data = {2'b10, shreg};
            dstate_n  = D_BASE;
          end
        end
        D_BRK: begin
          push      = 1'b1;
          push_data = {2'b01, shreg};
          dstate_n  = D_BASE;
        end
        default: begin
          push      = 1'b1;
          push_data = {2'b11, shreg};
          dstate_n  = D_BASE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dstate <= D_BASE;
    else     dstate <= dstate_n;
  end

  assign full = (count == (AW+1)'(FIFO_DEPTH));
  assign pop  = evt.evt_valid & evt.evt_ready;
  assign wr   = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !wr) overflow <= 1'b1;
    end
  end

  assign head            = mem[rp];
  assign evt.evt_valid   = (count != '0);
  assign evt.evt_code    = evt.evt_valid ? head[7:0] : '0;
  assign evt.evt_release = evt.evt_valid & head[8];
  assign evt.evt_ext     = evt.evt_valid & head[9];
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: frames driven on kclk/kdata, events collected at the consumer.
module tb_ps2_key_event_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic kclk = 1'b1;
  logic kdata = 1'b1;
  logic frame_err, overflow;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  logic [9:0] q [$];

  ps2_key_event_ctrl_if evt ();

  ps2_key_event_ctrl #(
    .SYNC_STAGES(2),
    .FIFO_DEPTH(4),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kclk(kclk),
    .kdata(kdata),
    .evt(evt.master),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (evt.evt_valid && evt.evt_ready) q.push_back({evt.evt_ext, evt.evt_release, evt.evt_code});
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic send_bits(input logic [7:0] d, input logic p, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kdata = fr[i];
      wait_clk(10);
      kclk = 1'b0;
      wait_clk(20);
      kclk = 1'b1;
      wait_clk(10);
    end
    kdata = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bits(d, odd_par(d), 11);
    wait_clk(10);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_clk(4);
    checks++;
    if ({evt.evt_valid, evt.evt_code, evt.evt_ext, evt.evt_release, frame_err, overflow} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b code=%h ext=%b rel=%b ferr=%b ovf=%b want all 0",
               evt.evt_valid, evt.evt_code, evt.evt_ext, evt.evt_release, frame_err, overflow);
    end
    rst = 1'b0;
    wait_clk(5);
  endtask

  task automatic test_make;
    int f0;
    f0 = ferr_cnt;
    q.delete();
    evt.evt_ready = 1'b1;
    send_byte(8'h1C);
    checks++;
    if (q.size() != 1 || q[0] !== 10'h01C) begin
      errors++;
      $display("FAIL make_1c got n=%0d first=%h want n=1 first=01c", q.size(), (q.size() > 0) ? q[0] : 10'h3FF);
    end
    checks++;
    if (ferr_cnt != f0) begin
      errors++;
      $display("FAIL make_ferr got %0d pulses want 0", ferr_cnt - f0);
    end
  endtask

  task automatic test_break;
    q.delete();
    send_byte(8'hF0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL brk_prefix_noevt got n=%0d want 0", q.size());
    end
    send_byte(8'h1C);
    checks++;
    if (q.size() != 1 || q[0] !== 10'h11C) begin
      errors++;
      $display("FAIL brk_1c got n=%0d first=%h want n=1 first=11c", q.size(), (q.size() > 0) ? q[0] : 10'h3FF);
    end
  endtask

  task automatic test_ext;
    q.delete();
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    checks++;
    if (q.size() != 1 || q[0] !== 10'h375) begin
      errors++;
      $display("FAIL ext_brk_75 got n=%0d first=%h want n=1 first=375", q.size(), (q.size() > 0) ? q[0] : 10'h3FF);
    end
    q.delete();
    send_byte(8'h29);
    checks++;
    if (q.size() != 1 || q[0] !== 10'h029) begin
      errors++;
      $display("FAIL prefix_clear_29 got n=%0d first=%h want n=1 first=029", q.size(), (q.size() > 0) ? q[0] : 10'h3FF);
    end
    q.delete();
    send_byte(8'hE0);
    send_byte(8'hE0);
    send_byte(8'h6B);
    send_byte(8'hAA);
    checks++;
    if (q.size() != 1 || q[0] !== 10'h26B) begin
      errors++;
      $display("FAIL ext_make_6b got n=%0d first=%h want n=1 first=26b", q.size(), (q.size() > 0) ? q[0] : 10'h3FF);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] codes [5];
    logic [7:0] want  [4];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    want  = '{8'h15, 8'h1D, 8'h24, 8'h2D};
    evt.evt_ready = 1'b0;
    q.delete();
    for (int i = 0; i < 5; i++) send_byte(codes[i]);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got %b want 1", overflow);
    end
    wait_clk(3);
    checks++;
    if (evt.evt_valid !== 1'b1 || evt.evt_code !== 8'h15) begin
      errors++;
      $display("FAIL ovf_head_stable got valid=%b code=%h want valid=1 code=15", evt.evt_valid, evt.evt_code);
    end
    evt.evt_ready = 1'b1;
    wait_clk(10);
    checks++;
    if (q.size() != 4) begin
      errors++;
      $display("FAIL ovf_drain_count got %0d want 4", q.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= q.size() || q[i] !== {2'b00, want[i]}) begin
        errors++;
        $display("FAIL ovf_drain_%0d got %h want %h", i, (i < q.size()) ? q[i] : 10'h3FF, {2'b00, want[i]});
      end
    end
  endtask

  task automatic test_timeout;
    int f0;
    q.delete();
    f0 = ferr_cnt;
    send_bits(8'h1C, 1'b0, 6);
    wait_clk(300);
    checks++;
    if (ferr_cnt - f0 != 1 || q.size() != 0) begin
      errors++;
      $display("FAIL timeout got ferr=%0d events=%0d want ferr=1 events=0", ferr_cnt - f0, q.size());
    end
    send_byte(8'h1C);
    checks++;
    if (q.size() != 1 || q[0] !== 10'h01C) begin
      errors++;
      $display("FAIL timeout_recover got n=%0d first=%h want n=1 first=01c", q.size(), (q.size() > 0) ? q[0] : 10'h3FF);
    end
  endtask

  task automatic test_parity;
    int f0;
    q.delete();
    f0 = ferr_cnt;
    send_bits(8'h1C, 1'b1, 11);
    wait_clk(10);
    checks++;
`ifdef PS2_PARITY_CHECK_EN
    if (ferr_cnt - f0 != 1 || q.size() != 0) begin
      errors++;
      $display("FAIL parity_bad got ferr=%0d events=%0d want ferr=1 events=0", ferr_cnt - f0, q.size());
    end
`else
    if (ferr_cnt - f0 != 0 || q.size() != 1 || q[0] !== 10'h01C) begin
      errors++;
      $display("FAIL parity_ignored got ferr=%0d events=%0d want ferr=0 events=1 code=01c", ferr_cnt - f0, q.size());
    end
`endif
  endtask

  task automatic test_rst_midframe;
    evt.evt_ready = 1'b0;
    send_byte(8'h29);
    send_bits(8'h5A, 1'b0, 4);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(1);
    checks++;
    if (evt.evt_valid !== 1'b0 || overflow !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_flush got valid=%b ovf=%b ferr=%b want 0 0 0", evt.evt_valid, overflow, frame_err);
    end
    q.delete();
    evt.evt_ready = 1'b1;
    send_byte(8'h1C);
    checks++;
    if (q.size() != 1 || q[0] !== 10'h01C) begin
      errors++;
      $display("FAIL rst_recover got n=%0d first=%h want n=1 first=01c", q.size(), (q.size() > 0) ? q[0] : 10'h3FF);
    end
  endtask

  initial begin
    evt.evt_ready = 1'b1;
    test_reset();
    test_make();
    test_break();
    test_ext();
    test_overflow();
    test_timeout();
    test_parity();
    test_rst_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
